// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-request controller for the IF stage.
// Optional misaligned-redirect trapping is enabled by defining PC_MISALIGN_CHECK_EN.
module pc_fetch_ctrl #(
  parameter int unsigned         XLEN       = 32,
  parameter logic [XLEN-1:0]     RESET_VEC  = 32'h0,
  parameter logic [XLEN-1:0]     EXC_VEC    = 32'h100,
  parameter int unsigned         INC        = 4,
  parameter int unsigned         ALIGN_BITS = 2,
  parameter int unsigned         CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             exc_i,
  input  logic             fetch_ack_i,
  output logic             fetch_req_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             kill_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic             misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t           r_state, w_state_next;
  logic [XLEN-1:0]  r_pc, w_pc_next;
  logic [XLEN-1:0]  r_pend_pc, w_pend_pc_next;
  logic             r_pend_v, w_pend_v_next;
  logic             r_pend_exc, w_pend_exc_next;
  logic             r_halt_seen, w_halt_seen_next;
  logic             r_kill, w_kill_next;
  logic             r_stall_hold, w_stall_hold_next;
  logic [CNT_W-1:0] r_cnt;

  logic             w_req, w_xfer, w_outstanding;
  logic [XLEN-1:0]  w_redir_pc;
  logic             w_redir_exc;

`ifdef PC_MISALIGN_CHECK_EN
  logic w_mis;
  logic r_misalign;

  // A misaligned target traps, so it behaves like an exception for pending priority.
  assign w_mis       = |(redirect_pc_i & ALIGN_MASK);
  assign w_redir_pc  = w_mis ? EXC_VEC : redirect_pc_i;
  assign w_redir_exc = w_mis;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_misalign <= 1'b0;
    else        r_misalign <= redirect_i & w_mis;
  end
  assign misalign_o = r_misalign;
`else
  assign w_redir_pc  = redirect_pc_i & ~ALIGN_MASK;
  assign w_redir_exc = 1'b0;
  assign misalign_o  = 1'b0;
`endif

  always_comb begin
    case (r_state)
      S_RUN:   w_req = ~stall_i & ~r_stall_hold;
      S_WAIT:  w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  assign w_xfer        = w_req & fetch_ack_i;
  assign w_outstanding = w_req & ~fetch_ack_i;

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_pend_pc_next    = r_pend_pc;
    w_pend_v_next     = r_pend_v;
    w_pend_exc_next   = r_pend_exc;
    w_halt_seen_next  = r_halt_seen;
    w_kill_next       = 1'b0;
    w_stall_hold_next = 1'b0;

    // While a request is in flight pc_o must not move, so targets are parked.
    if (w_outstanding) begin
      if (exc_i) begin
        w_pend_pc_next  = EXC_VEC;
        w_pend_v_next   = 1'b1;
        w_pend_exc_next = 1'b1;
      end else if (redirect_i && !(r_pend_v && r_pend_exc)) begin
        w_pend_pc_next  = w_redir_pc;
        w_pend_v_next   = 1'b1;
        w_pend_exc_next = w_redir_exc;
      end
    end else begin
      if (exc_i)                      w_pc_next = EXC_VEC;
      else if (r_pend_v && r_pend_exc) w_pc_next = r_pend_pc;
      else if (redirect_i)            w_pc_next = w_redir_pc;
      else if (r_pend_v)              w_pc_next = r_pend_pc;
      else if (w_xfer)                w_pc_next = r_pc + XLEN'(INC);
      w_pend_v_next   = 1'b0;
      w_pend_exc_next = 1'b0;
      w_kill_next     = w_xfer & (exc_i | redirect_i | r_pend_v);
    end

    case (r_state)
      S_IDLE, S_HALT: begin
        if (start_i) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_outstanding) begin
          w_state_next     = S_WAIT;
          w_halt_seen_next = halt_i;
        end else if (halt_i) begin
          w_state_next = S_HALT;
        end
      end
      S_WAIT: begin
        w_halt_seen_next = r_halt_seen | halt_i;
        if (fetch_ack_i) begin
          w_state_next      = (r_halt_seen | halt_i) ? S_HALT : S_RUN;
          w_halt_seen_next  = 1'b0;
          w_stall_hold_next = stall_i;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_VEC;
      r_pend_pc    <= RESET_VEC;
      r_pend_v     <= 1'b0;
      r_pend_exc   <= 1'b0;
      r_halt_seen  <= 1'b0;
      r_kill       <= 1'b0;
      r_stall_hold <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_pend_pc    <= w_pend_pc_next;
      r_pend_v     <= w_pend_v_next;
      r_pend_exc   <= w_pend_exc_next;
      r_halt_seen  <= w_halt_seen_next;
      r_kill       <= w_kill_next;
      r_stall_hold <= w_stall_hold_next;
      r_cnt        <= r_cnt + CNT_W'(w_xfer);
    end
  end

  assign fetch_req_o = w_req;
  assign pc_o        = r_pc;
  assign kill_o      = r_kill;
  assign halted_o    = (r_state == S_IDLE) || (r_state == S_HALT);
  assign fetch_cnt_o = r_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a stimulus table plus a reset-mid-transfer sequence.
// Expected misalign behaviour follows PC_MISALIGN_CHECK_EN when defined for the build.
module tb_pc_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0, halt_i = 1'b0, stall_i = 1'b0;
  logic        redirect_i = 1'b0, exc_i = 1'b0, fetch_ack_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        fetch_req_o, kill_o, halted_o, misalign_o;
  logic [31:0] pc_o;
  logic [15:0] fetch_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

`ifdef PC_MISALIGN_CHECK_EN
  localparam logic [31:0] MIS_PC   = 32'h100;
  localparam logic        MIS_FLAG = 1'b1;
`else
  localparam logic [31:0] MIS_PC   = 32'h40;
  localparam logic        MIS_FLAG = 1'b0;
`endif

  pc_fetch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .exc_i(exc_i), .fetch_ack_i(fetch_ack_i), .fetch_req_o(fetch_req_o),
    .pc_o(pc_o), .kill_o(kill_o), .halted_o(halted_o),
    .fetch_cnt_o(fetch_cnt_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start, halt, stall, redir;
    logic [31:0] rpc;
    logic        exc, ack;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic        exp_kill, exp_halted;
    logic [15:0] exp_cnt;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(logic st, logic ht, logic sl, logic rd, logic [31:0] rpc,
                              logic ex, logic ak, logic req, logic [31:0] pc,
                              logic kl, logic hl, logic [15:0] cnt, logic mis);
    vec_t v;
    v.start = st; v.halt = ht; v.stall = sl; v.redir = rd; v.rpc = rpc;
    v.exc = ex; v.ack = ak; v.exp_req = req; v.exp_pc = pc; v.exp_kill = kl;
    v.exp_halted = hl; v.exp_cnt = cnt; v.exp_mis = mis;
    return v;
  endfunction

  task automatic cmp(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outputs(vec_t e, int idx);
    cmp("fetch_req", idx, 32'(fetch_req_o), 32'(e.exp_req));
    cmp("pc",        idx, pc_o,             e.exp_pc);
    cmp("kill",      idx, 32'(kill_o),      32'(e.exp_kill));
    cmp("halted",    idx, 32'(halted_o),    32'(e.exp_halted));
    cmp("fetch_cnt", idx, 32'(fetch_cnt_o), 32'(e.exp_cnt));
    cmp("misalign",  idx, 32'(misalign_o),  32'(e.exp_mis));
  endtask

  // Inputs change on the falling edge; outputs are sampled 2ns later, well before the rising edge.
  task automatic apply(vec_t v, int idx);
    vec_t e;
    @(negedge clk_i);
    start_i = v.start; halt_i = v.halt; stall_i = v.stall; redirect_i = v.redir;
    redirect_pc_i = v.rpc; exc_i = v.exc; fetch_ack_i = v.ack;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    check_outputs(e, idx);
    $display("step %0d: req=%b pc=%h kill=%b halted=%b cnt=%0d mis=%b",
             idx, fetch_req_o, pc_o, kill_o, halted_o, fetch_cnt_o, misalign_o);
  endtask

  initial begin
    //                st ht sl rd rpc           ex ak  req pc            kl hl cnt mis
    // sequential fetch with ack always high
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 1, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h0,        0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h4,        0, 0, 1,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h8,        0, 0, 2,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'hC,        0, 0, 3,  0));
    // three-cycle stall freezes pc and drops req
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 32'h10,       0, 0, 4,  0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 32'h10,       0, 0, 4,  0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 32'h10,       0, 0, 4,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h10,       0, 0, 4,  0));
    // redirect deferred while ack is low
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,  1, 32'h14,       0, 0, 5,  0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h40,       0, 0,  1, 32'h14,       0, 0, 5,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,  1, 32'h14,       0, 0, 5,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h14,       0, 0, 5,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h40,       1, 0, 6,  0));
    // exception beats redirect; pending exception not overwritten
    tbl.push_back(mk(0, 0, 0, 1, 32'h80,       1, 1,  1, 32'h44,       0, 0, 7,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,  1, 32'h100,      1, 0, 8,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0,  1, 32'h100,      0, 0, 8,  0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h200,      0, 0,  1, 32'h100,      0, 0, 8,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h100,      0, 0, 8,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h100,      1, 0, 9,  0));
    // halt seen during WAIT takes effect after ack; start resumes at pc+4
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,  1, 32'h104,      0, 0, 10, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0,  1, 32'h104,      0, 0, 10, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h104,      0, 0, 10, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  0, 32'h108,      0, 1, 11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  0, 32'h108,      0, 1, 11, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1,  0, 32'h108,      0, 1, 11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h108,      0, 0, 11, 0));
    // stall together with ack in WAIT: no request on the following cycle
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,  1, 32'h10C,      0, 0, 12, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 1,  1, 32'h10C,      0, 0, 12, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  0, 32'h110,      0, 0, 13, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'h110,      0, 0, 13, 0));
    // wrap at top of address space, then misaligned redirect
    tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1, 1, 32'h114,      0, 0, 14, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 32'hFFFF_FFFC, 1, 0, 15, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h42,       0, 1,  1, 32'h0,        0, 0, 16, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  0, MIS_PC,       1, 0, 17, MIS_FLAG));
    // halt in RUN with no request, then redirect/exception still move pc while halted
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0,  0, MIS_PC,       0, 0, 17, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h80,       0, 0,  0, MIS_PC,       0, 1, 17, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0,  0, 32'h80,       0, 1, 17, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,  0, 32'h100,      0, 1, 17, 0));

    // reset state
    #3;
    check_outputs(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 0, 0), -1);
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // reset asserted mid-transfer discards the request and the pending redirect
    apply(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h100, 0, 1, 17, 0), 100);
    apply(mk(0, 0, 0, 0, 32'h0,   0, 0, 1, 32'h100, 0, 0, 17, 0), 101);
    apply(mk(0, 0, 0, 1, 32'h300, 0, 0, 1, 32'h100, 0, 0, 17, 0), 102);
    @(negedge clk_i);
    #2;
    start_i = 0; halt_i = 0; stall_i = 0; redirect_i = 0; exc_i = 0; fetch_ack_i = 0;
    redirect_pc_i = 32'h0;
    rst_i = 1'b0;
    #1;
    check_outputs(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 0, 0), 103);
    $display("step 103: async reset mid-transfer pc=%h halted=%b", pc_o, halted_o);
    @(negedge clk_i);
    rst_i = 1'b1;
    apply(mk(1, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 0), 104);
    apply(mk(0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h0, 0, 0, 0, 0), 105);
    apply(mk(0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h4, 0, 0, 1, 0), 106);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
